// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared unit-size codes, FSM states and legality check for the data-memory responder
package dmem_responder_pkg;

  localparam logic [2:0] UNIT_B  = 3'b000;
  localparam logic [2:0] UNIT_H  = 3'b001;
  localparam logic [2:0] UNIT_W  = 3'b010;
  localparam logic [2:0] UNIT_BU = 3'b100;
  localparam logic [2:0] UNIT_HU = 3'b101;

  localparam int DMEM_WAIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } dmemState_t;

  // Unsigned sizes exist only for loads; halves need even and words need 4-aligned addresses.
  function automatic logic isIllegal(input logic [2:0] unitSize, input logic [1:0] addrLo,
                                     input logic isStore);
    case (unitSize)
      UNIT_B:  return 1'b0;
      UNIT_BU: return isStore;
      UNIT_H:  return addrLo[0];
      UNIT_HU: return isStore | addrLo[0];
      UNIT_W:  return |addrLo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_lane_align.sv
// rtl/dmem_responder_lane_align.sv - store lane replication and load lane select with extension
module dmem_responder_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  unitSize,
  input  logic [1:0]  addrLo,
  input  logic [31:0] storeWord,
  input  logic [31:0] loadWord,
  output logic [3:0]  storeMask,
  output logic [31:0] storeData,
  output logic [31:0] loadData
);

  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  // Replicate store data across lanes so the mask alone picks the bytes written
  always_comb begin
    storeMask = 4'b1111;
    storeData = storeWord;
    case (unitSize)
      UNIT_B, UNIT_BU: begin
        storeMask = 4'b0001 << addrLo;
        storeData = {4{storeWord[7:0]}};
      end
      UNIT_H, UNIT_HU: begin
        storeMask = 4'b0011 << {addrLo[1], 1'b0};
        storeData = {2{storeWord[15:0]}};
      end
      default: begin
        storeMask = 4'b1111;
        storeData = storeWord;
      end
    endcase
  end

  // Pick the addressed byte/half out of the SRAM word and extend it to 32 bits
  always_comb begin
    case (addrLo)
      2'd0:    loadByte = loadWord[7:0];
      2'd1:    loadByte = loadWord[15:8];
      2'd2:    loadByte = loadWord[23:16];
      default: loadByte = loadWord[31:24];
    endcase
    loadHalf = addrLo[1] ? loadWord[31:16] : loadWord[15:0];
    case (unitSize)
      UNIT_B:  loadData = {{24{loadByte[7]}}, loadByte};
      UNIT_BU: loadData = {24'd0, loadByte};
      UNIT_H:  loadData = {{16{loadHalf[15]}}, loadHalf};
      UNIT_HU: loadData = {16'd0, loadHalf};
      default: loadData = loadWord;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder driving a wait-stated synchronous SRAM with core stall
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0,
  parameter int SRAM_AW     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               memRead,
  input  logic               memWrite,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [2:0]         unitSize,
  input  logic [DATA_W-1:0]  writeData,
  output logic [DATA_W-1:0]  readData,
  output logic               busy,
  output logic               done,
  output logic               accessErr,
  output logic               sram_en,
  output logic               sram_we,
  output logic [3:0]         sram_wmask,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  input  logic [DATA_W-1:0]  sram_rdata
);

  localparam logic [DMEM_WAIT_W-1:0] WAIT_INIT =
    (WAIT_STATES > 0) ? DMEM_WAIT_W'(WAIT_STATES - 1) : '0;

  dmemState_t             state;
  logic [SRAM_AW+1:0]     reqAddr;
  logic [2:0]             reqSize;
  logic [DATA_W-1:0]      reqData;
  logic                   reqStore;
  logic [DMEM_WAIT_W-1:0] waitCnt;

  logic                   hasReq;
  logic [3:0]             laneMask;
  logic [31:0]            laneData;
  logic [31:0]            laneLoad;

  // Address bits above the SRAM window wrap and are intentionally ignored
  logic unusedAddrBits;
  assign unusedAddrBits = ^addr[ADDR_W-1:SRAM_AW+2];

  assign hasReq = memRead | memWrite;

  dmem_responder_lane_align u_laneAlign (
    .unitSize (reqSize),
    .addrLo   (reqAddr[1:0]),
    .storeWord(reqData),
    .loadWord (sram_rdata),
    .storeMask(laneMask),
    .storeData(laneData),
    .loadData (laneLoad)
  );

  // Request sequencing: accept, optional wait, SRAM access, capture and one-cycle completion pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      readData  <= '0;
      done      <= 1'b0;
      accessErr <= 1'b0;
      waitCnt   <= '0;
      reqAddr   <= '0;
      reqSize   <= '0;
      reqData   <= '0;
      reqStore  <= 1'b0;
    end else begin
      done      <= 1'b0;
      accessErr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hasReq) begin
            reqAddr  <= addr[SRAM_AW+1:0];
            reqSize  <= unitSize;
            reqData  <= writeData;
            reqStore <= memWrite;
            if (isIllegal(unitSize, addr[1:0], memWrite)) begin
              state     <= ST_ERR;
              accessErr <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state   <= ST_WAIT;
              waitCnt <= WAIT_INIT;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_WAIT: begin
          if (waitCnt == '0) begin
            state <= ST_ISSUE;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        ST_ISSUE: begin
          if (reqStore) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          readData <= laneLoad;
          state    <= ST_DONE;
          done     <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stall and SRAM strobes decode straight from the state and the latched request
  always_comb begin
    busy       = (state == ST_IDLE && hasReq) || state == ST_WAIT ||
                 state == ST_ISSUE || state == ST_CAPTURE;
    sram_en    = rst && (state == ST_ISSUE);
    sram_we    = sram_en && reqStore;
    sram_wmask = sram_we ? laneMask : 4'b0000;
    sram_addr  = reqAddr[SRAM_AW+1:2];
    sram_wdata = laneData;
  end

endmodule
